// File: rtl/somador_pkg.sv
// somador_pkg: shared state encoding and sizing helper for the digit-serial adder.
package somador_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        SOMANDO,
        PRONTO
    } estado_t;

    function automatic int cnt_width(input int ciclos);
        return (ciclos > 1) ? $clog2(ciclos) : 1;
    endfunction

endpackage

// File: rtl/somador_bit.sv
// somador_bit: one-bit full adder, chained DIGIT times to form the per-clock slice.
module somador_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/somador_serial.sv
// somador_serial: digit-serial WIDTH-bit adder with valid/ready handshakes.
// Define SOMADOR_OVF_EN to add the registered signed-overflow output ovf.
module somador_serial
    import somador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef SOMADOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CICLOS = WIDTH / DIGIT;
    localparam int CW     = cnt_width(CICLOS);
    localparam logic [CW-1:0] ULTIMO = CW'(CICLOS - 1);

    generate
        if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_param_err
            $error("somador_serial: invalid WIDTH/DIGIT combination");
        end
    endgenerate

    estado_t estado;
    estado_t prox;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] s_reg;
    logic [WIDTH-1:0] s_next;
    logic             carry;
    logic [CW-1:0]    count;
    logic [DIGIT-1:0] fatia_s;
    logic [DIGIT:0]   c;

    assign c[0] = carry;

    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_fatia
            somador_bit u_bit (
                .a   (a_reg[i]),
                .b   (b_reg[i]),
                .cin (c[i]),
                .s   (fatia_s[i]),
                .cout(c[i+1])
            );
        end
    endgenerate

    // New digits enter at the top so the LSB digit ends at bit 0 after CICLOS shifts.
    assign s_next = WIDTH'({fatia_s, s_reg} >> DIGIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= prox;
        end
    end

    always_comb begin
        prox = estado;
        unique case (estado)
            OCIOSO:  if (in_valid) prox = SOMANDO;
            SOMANDO: if (count == ULTIMO) prox = PRONTO;
            PRONTO:  if (out_ready) prox = OCIOSO;
            default: prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            carry <= 1'b0;
            count <= '0;
        end else begin
            unique case (estado)
                OCIOSO: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        count <= '0;
                    end
                end
                SOMANDO: begin
                    a_reg <= a_reg >> DIGIT;
                    b_reg <= b_reg >> DIGIT;
                    s_reg <= s_next;
                    carry <= c[DIGIT];
                    count <= count + CW'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef SOMADOR_OVF_EN
    logic ovf_reg;

    // In the final digit, c[DIGIT-1] is the carry into the operand MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (estado == SOMANDO && count == ULTIMO) begin
            ovf_reg <= c[DIGIT-1] ^ c[DIGIT];
        end
    end

    assign ovf = out_valid & ovf_reg;
`endif

    assign in_ready  = (estado == OCIOSO);
    assign out_valid = (estado == PRONTO);
    assign s         = out_valid ? s_reg : '0;
    assign cout      = out_valid & carry;

endmodule

// File: tb/tb_somador_serial.sv
// tb_somador_serial: scoreboard bench for a DIGIT=1 and a DIGIT=4 adder instance.
// Define SOMADOR_OVF_EN to also check the ovf output.
module tb_somador_serial;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       ci;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    // Hand-computed: {co,s} = a + b + ci, ov = signed overflow.
    vec_t tab [10] = '{
        '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
        '{8'h3C, 8'h0F, 1'b1, 8'h4C, 1'b0, 1'b0},
        '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
        '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1},
        '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0},
        '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0},
        '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0},
        '{8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0},
        '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0},
        '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1}
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid_v  [2];
    logic       in_ready_v  [2];
    logic [7:0] a_v         [2];
    logic [7:0] b_v         [2];
    logic       cin_v       [2];
    logic       out_valid_v [2];
    logic       out_ready_v [2];
    logic [7:0] s_v         [2];
    logic       cout_v      [2];
`ifdef SOMADOR_OVF_EN
    logic       ovf_v       [2];
`endif

    int checks = 0;
    int errors = 0;
    vec_t q0[$];
    vec_t q1[$];

    always #5 clk = ~clk;

    somador_serial #(.WIDTH(8), .DIGIT(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_v[0]),
        .in_ready (in_ready_v[0]),
        .a        (a_v[0]),
        .b        (b_v[0]),
        .cin      (cin_v[0]),
        .out_valid(out_valid_v[0]),
        .out_ready(out_ready_v[0]),
        .s        (s_v[0]),
        .cout     (cout_v[0])
`ifdef SOMADOR_OVF_EN
        ,
        .ovf      (ovf_v[0])
`endif
    );

    somador_serial #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid_v[1]),
        .in_ready (in_ready_v[1]),
        .a        (a_v[1]),
        .b        (b_v[1]),
        .cin      (cin_v[1]),
        .out_valid(out_valid_v[1]),
        .out_ready(out_ready_v[1]),
        .s        (s_v[1]),
        .cout     (cout_v[1])
`ifdef SOMADOR_OVF_EN
        ,
        .ovf      (ovf_v[1])
`endif
    );

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic score(input int d);
        vec_t e;
        if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
            chk($sformatf("unexpected_result_dut%0d", d), 1, 0);
            return;
        end
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("sum_dut%0d", d), {cout_v[d], s_v[d]}, {e.co, e.s});
`ifdef SOMADOR_OVF_EN
        chk($sformatf("ovf_dut%0d", d), ovf_v[d], e.ov);
`endif
    endtask

    // Monitor: inputs change on negedge, so sample shortly after it.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            for (int d = 0; d < 2; d++) begin
                if (out_valid_v[d] && out_ready_v[d]) score(d);
            end
        end
    end

    task automatic send(input int d, input int k, input bit push);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready_v[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("send_timeout", 1, 0);
            return;
        end
        a_v[d]        = tab[k].a;
        b_v[d]        = tab[k].b;
        cin_v[d]      = tab[k].ci;
        in_valid_v[d] = 1'b1;
        if (push) begin
            if (d == 0) q0.push_back(tab[k]);
            else        q1.push_back(tab[k]);
        end
        @(posedge clk);
        #1;
        in_valid_v[d] = 1'b0;
    endtask

    task automatic wait_valid(input int d, output int n);
        n = 0;
        while (!out_valid_v[d] && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_out_valid"}, out_valid_v[0], 0);
        chk({nm, "_in_ready"}, in_ready_v[0], 1);
        chk({nm, "_s"}, s_v[0], 0);
        chk({nm, "_cout"}, cout_v[0], 0);
`ifdef SOMADOR_OVF_EN
        chk({nm, "_ovf"}, ovf_v[0], 0);
`endif
    endtask

    initial begin
        int n;
        int t [3];
        int got;
        int cyc;
        int k0 [6] = '{0, 1, 2, 3, 4, 5};
        int k1 [4] = '{1, 0, 6, 7};

        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            in_valid_v[d]  = 1'b0;
            a_v[d]         = '0;
            b_v[d]         = '0;
            cin_v[d]       = 1'b0;
            out_ready_v[d] = 1'b1;
        end
        #1;
        chk_idle("reset");
        chk("reset_in_ready_dut4", in_ready_v[1], 1);
        chk("reset_out_valid_dut4", out_valid_v[1], 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (k0[i]) begin
            send(0, k0[i], 1'b1);
            wait_valid(0, n);
            chk("latency_digit1", n, 8);
        end

        foreach (k1[i]) begin
            send(1, k1[i], 1'b1);
            wait_valid(1, n);
            chk("latency_digit4", n, 2);
        end

        // Result must hold while the consumer stalls; new operands are ignored.
        out_ready_v[0] = 1'b0;
        send(0, 9, 1'b1);
        wait_valid(0, n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid_v[0] = 1'b1;
            a_v[0]        = 8'h11;
            b_v[0]        = 8'h22;
            cin_v[0]      = 1'b1;
            chk("hold_out_valid", out_valid_v[0], 1);
            chk("hold_sum", {cout_v[0], s_v[0]}, 9'h080);
            chk("hold_in_ready", in_ready_v[0], 0);
        end
        @(negedge clk);
        in_valid_v[0]  = 1'b0;
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_handshake_out_valid", out_valid_v[0], 0);
        chk("post_handshake_in_ready", in_ready_v[0], 1);

        // Abort mid-operation at count 3 of 8.
        send(0, 3, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        send(0, 3, 1'b1);
        wait_valid(0, n);
        chk("latency_after_reset", n, 8);

        // Back-to-back with both handshakes held high.
        @(negedge clk);
        a_v[0]        = tab[6].a;
        b_v[0]        = tab[6].b;
        cin_v[0]      = tab[6].ci;
        in_valid_v[0] = 1'b1;
        for (int i = 0; i < 3; i++) q0.push_back(tab[6]);
        got = 0;
        cyc = 0;
        while (got < 3 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid_v[0]) begin
                t[got] = cyc;
                got++;
            end
        end
        in_valid_v[0] = 1'b0;
        chk("b2b_results", got, 3);
        if (got == 3) begin
            chk("b2b_interval_1", t[1] - t[0], 10);
            chk("b2b_interval_2", t[2] - t[1], 10);
        end

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        chk("scoreboard_drained_dut1", q0.size(), 0);
        chk("scoreboard_drained_dut4", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
